// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle adder/subtractor that adds CHUNK bits per clock,
// LSB chunk first, with the inter-chunk carry held in a register.
// Handshake: in_valid/in_ready on operands, out_valid/out_ready on the result.
// Optional macro SEQ_CHUNK_ADDER_OVF_EN adds a signed-overflow output 'ovf'.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cy_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cy_out
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  , output logic           ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Reject geometries the chunked datapath cannot cover exactly.
  generate
    if ((WIDTH < 2) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
      $error("seq_chunk_adder: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cy_q, cy_d;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Current chunk of the (possibly inverted) operands and its CHUNK-bit add.
  int               lo;
  logic [CHUNK-1:0] a_ch, b_ch;
  logic [CHUNK:0]   add_w;
  logic             last_w;

  // Chunk slice and narrow adder shared by every BUSY cycle.
  always_comb begin
    lo     = int'(cnt_q) * CHUNK;
    a_ch   = a_q[lo +: CHUNK];
    b_ch   = b_q[lo +: CHUNK];
    add_w  = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
    last_w = (cnt_q == CW'(NCHUNK - 1));
  end

  // Next-state logic: accept in IDLE, one chunk per BUSY cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cy_d    = cy_q;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + ~borrow, so cy_out becomes not-borrow.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? ~cy_in : cy_in;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        sum_d[lo +: CHUNK] = add_w[CHUNK-1:0];
        carry_d            = add_w[CHUNK];
        if (last_w) begin
          cy_d    = add_w[CHUNK];
`ifdef SEQ_CHUNK_ADDER_OVF_EN
          // Carry into the MSB recovered from its sum bit; overflow when it
          // disagrees with the carry out of the MSB.
          ovf_d   = (add_w[CHUNK-1] ^ a_ch[CHUNK-1] ^ b_ch[CHUNK-1]) ^ add_w[CHUNK];
`endif
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cy_q    <= cy_d;
    end
  end

`ifdef SEQ_CHUNK_ADDER_OVF_EN
  // Overflow flag, updated only on the final chunk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cy_out    = cy_q;

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Parametrised multi-cycle adder/subtractor. Successor to the single-bit and 4-bit ripple adders.
- Adds two WIDTH-bit operands CHUNK bits per clock. The carry is held in a register between chunks.
- Valid/ready handshake on both input and output, so it drops into streaming datapaths.
- Trades latency for a small CHUNK-bit adder core.

Parameters:
- WIDTH, 16, operand and result width in bits; must be >= 2.
- CHUNK, 4, bits added per cycle; must divide WIDTH exactly (elaboration-time check, $error if not).
- NCHUNK, WIDTH/CHUNK, derived localparam; not overridable.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set a/b/cy_in/sub is valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cy_in  input  1  carry in (add) / borrow in (sub).
- sub  input  1  0: a+b+cy_in; 1: a-b-cy_in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cy_out  output  1  carry out (add) / not-borrow (sub).

Behaviour:
- Reset: clk single clock; rst_n asynchronous, active-low.
  - While rst_n=0: state=IDLE, out_valid=0, sum=0, cy_out=0, chunk counter=0, carry reg=0.
  - in_ready is a combinational decode of state==IDLE, so it reads 1 during reset.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register the operands: a_r=a; b_r = sub ? ~b : b; carry reg = sub ? ~cy_in : cy_in.
  - Set cnt=0 and go to BUSY.
- BUSY:
  - in_ready=0. Each cycle add chunk cnt: {c, s} = a_r[cnt*CHUNK +: CHUNK] + b_r[same] + carry.
  - Write s into sum[cnt*CHUNK +: CHUNK]; carry reg=c.
  - When cnt==NCHUNK-1: cy_out=c, out_valid=1, go to DONE. Otherwise cnt=cnt+1.
  - Chunks are processed LSB first.
- DONE:
  - out_valid=1; sum and cy_out held stable.
  - On out_ready=1: out_valid=0, go to IDLE.
  - in_ready=0 throughout DONE; operands presented during DONE are not taken.
- Latency: out_valid rises NCHUNK cycles after the accepting edge (4 for defaults).
- Minimum issue interval: NCHUNK+2 cycles (accept, NCHUNK adds, DONE handshake, back in IDLE).
- Sum register: reset clears sum. Bits of sum not yet written in BUSY hold the previous result and are undefined to the consumer until out_valid.
- Subtract semantics:
  - sub=1 gives sum = a-b-cy_in mod 2^WIDTH.
  - cy_out=1 iff a >= b+cy_in (unsigned, no borrow).
- Operand stability: a, b, cy_in and sub are sampled only at the accepting edge; changes afterwards have no effect.
- Output stability: out_valid=1 with out_ready=0 holds sum and cy_out indefinitely with no change.
- Degenerate case: CHUNK==WIDTH gives NCHUNK=1, a 1-cycle BUSY. Counter width is max(1, clog2(NCHUNK)).
- Reset mid-operation: rst_n low in BUSY or DONE aborts immediately. The partial result is discarded and the block is in IDLE with in_ready=1 after release.

Optional Feature:
- Macro: SEQ_CHUNK_ADDER_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit, reset 0): two's-complement signed overflow.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, using the inverted-b operand when sub=1.
  - Computed during the final chunk; valid and held with out_valid.
- Undefined: no ovf port and no associated logic; behaviour otherwise identical.

Test Plan:
- Defaults; a=0x1234, b=0x1111, cy_in=0, sub=0 -> out_valid exactly 4 cycles after accept, sum=0x2345, cy_out=0.
- a=0xFFFF, b=0x0001, cy_in=0 -> carry ripples through all chunks; sum=0x0000, cy_out=1. Repeat with a=0xFFFF, b=0x0000, cy_in=1 -> same result.
- sub=1, a=0x0005, b=0x0007, cy_in=0 -> sum=0xFFFE, cy_out=0. Then a=0x0007, b=0x0005, cy_in=1 -> sum=0x0001, cy_out=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while driving new in_valid with other operands:
  - sum and cy_out stay stable; in_ready=0; new operands ignored.
  - After the out_ready pulse, in_ready=1 next cycle.
- Reset: assert rst_n=0 asynchronously in BUSY cycle 2 -> out_valid, sum and cy_out go to 0 without a clock edge. After release, a=0x0101, b=0x0202 -> sum=0x0303.
- With SEQ_CHUNK_ADDER_OVF_EN:
  - 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cy_out=0.
  - 0x8000 sub 0x0001 -> sum=0x7FFF, ovf=1.
  - 0x0003+0x0004 -> ovf=0.
